lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
Load/store sequencing controller between the execute/memory pipeline stage and the single-port data memory. It accepts one request at a time and checks alignment. It then drives a held memory handshake with byte enables and lane-replicated store data, and configures the external load formatter through its mode, unsigned and byte-select inputs. It returns the formatted load data, or an error, through a response handshake.

Parameters:
TIMEOUT, 16, cycles to wait for mem_ready before aborting with an error; 0 disables the timeout.
CNT_W, 5, width of the timeout counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  asynchronous active-high reset.
req_valid  in  1  pipeline request valid.
req_ready  out  1  controller can accept a request (high only in IDLE).
req_we  in  1  1 = store, 0 = load.
req_addr  in  32  byte address.
req_wdata  in  32  store data, right-aligned.
req_mode  in  3  one-hot size: 001 = byte, 010 = half, 100 = word.
req_uint  in  1  load zero-extend (1) or sign-extend (0).
resp_valid  out  1  response available.
resp_ready  in  1  pipeline accepts the response.
resp_rdata  out  32  formatted load data; 0 for stores and errors.
resp_err  out  1  misaligned, illegal mode or timeout.
mem_en  out  1  memory access request, held until mem_ready.
mem_we  out  4  byte write enables.
mem_addr  out  32  word address ({req_addr[31:2], 2'b00}).
mem_wdata  out  32  lane-replicated store data.
mem_ready  in  1  memory completes the access this cycle.
mem_rdata  in  32  raw read word, valid when mem_ready = 1.
fmt_mode  out  3  formatter size select (latched req_mode).
fmt_uint  out  1  formatter extension select (latched req_uint).
fmt_cs  out  2  formatter byte select (latched req_addr[1:0]).
fmt_b0..fmt_b3  out  8 each  captured read bytes [7:0]..[31:24] fed to the formatter.
fmt_data  in  32  formatter result (combinational from the fmt_* outputs).

Behaviour:
- Reset (async):
  - state = IDLE; all registers cleared.
  - mem_en = 0, mem_we = 0, resp_valid = 0, resp_err = 0, resp_rdata = 0.
  - All fmt_* outputs = 0; req_ready = 1.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid: latch we, addr, wdata, mode and uint.
  - Error check, with cs = req_addr[1:0]:
    - mode not one-hot → error;
    - half with cs[0] = 1 → error;
    - word with cs != 0 → error.
  - Error → RESP with err = 1, with no memory access.
  - Otherwise → ACCESS; clear the counter.
- ACCESS:
  - mem_en = 1. mem_addr, mem_we and mem_wdata are stable from registers.
  - Store byte enables: byte → 0001 << cs; half → 0011 << cs; word → 1111.
  - Load: mem_we = 0.
  - Store data: byte → {4{wdata[7:0]}}; half → {2{wdata[15:0]}}; word → wdata.
  - On mem_ready: capture mem_rdata into fmt_b0..b3 (loads only) → RESP, err = 0.
  - Otherwise the counter increments. If TIMEOUT != 0 and the counter equals TIMEOUT-1 with no mem_ready → RESP with err = 1; mem_en drops the next cycle.
  - mem_ready on the last timeout cycle takes priority over the timeout (success).
- RESP:
  - resp_valid = 1.
  - resp_rdata = fmt_data for a successful load, else 0.
  - Hold until resp_ready, then → IDLE.
  - A new request is accepted no earlier than the cycle after the response handshake; no bypass.
- Latency: request accepted at cycle T.
  - mem_en is high from T+1.
  - If mem_ready arrives at T+1+k, resp_valid is high from T+2+k.
  - Error path: resp_valid at T+1.
- fmt_mode, fmt_uint and fmt_cs hold their latched values from acceptance until the next acceptance.
- mem_ready while not in ACCESS is ignored.
- req_valid outside IDLE is ignored (req_ready = 0).
- Reset mid-operation: mem_en and resp_valid drop immediately; the access is abandoned and no response is issued.

Decomposition:
- Shared package: FSM state encoding; MODE_B = 3'b001, MODE_H = 3'b010, MODE_W = 3'b100.
- Sub-module lsu_store_lane (combinational): mode + cs + wdata → mem_we, mem_wdata.

Test Plan:
- Aligned word load at 0x104, mem_ready 2 cycles after mem_en, rdata 0xDEADBEEF → mem_addr = 0x104, fmt_mode = 100, resp_rdata = 0xDEADBEEF, err = 0, resp_valid at T+4.
- Signed byte load at 0x203, rdata 0x80FF_0000 → fmt_cs = 3; resp_rdata = 0xFFFFFF80 with uint = 0, and 0x00000080 with uint = 1.
- Half store at 0x12, wdata 0x0000ABCD → mem_addr = 0x10, mem_we = 1100, mem_wdata = 0xABCDABCD; mem_ready same cycle → resp at T+2, rdata = 0.
- Word load at 0x101 and half at 0x103 → resp_err = 1 at T+1, mem_en never asserted; mode = 011 → err = 1.
- TIMEOUT = 16, mem_ready held low → mem_en high for exactly 16 cycles, then resp_err = 1. Repeat with mem_ready on the 16th cycle → err = 0.
- resp_ready low for 3 cycles → resp_valid and resp_rdata stable, req_ready = 0. Assert rst mid-ACCESS → mem_en = 0 immediately, then req_ready = 1, and no response is issued.

Source files
------------

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared types and constants for the load/store sequencing controller.
package lsu_mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  localparam logic [2:0] MODE_B = 3'b001;
  localparam logic [2:0] MODE_H = 3'b010;
  localparam logic [2:0] MODE_W = 3'b100;

  // Flags requests that must not reach memory.
  // Such requests use a non one-hot size, or are halfwords on odd bytes,
  // or are words off a word boundary.
  function automatic logic req_error(input logic [2:0] mode, input logic [1:0] cs);
    logic err;
    case (mode)
      MODE_B:  err = 1'b0;
      MODE_H:  err = cs[0];
      MODE_W:  err = (cs != 2'b00);
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/lsu_mem_ctrl_if.sv
// Bundle of the pipeline request/response, memory and formatter signals.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A source holds valid and its payload stable until that edge.
// The controller raises req_ready only in IDLE. It holds resp_valid,
// resp_rdata and resp_err until resp_ready. It holds mem_en and the mem_*
// payload until mem_ready.
interface lsu_mem_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_mode;
  logic        req_uint;

  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  logic        mem_en;
  logic [3:0]  mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  logic [2:0]  fmt_mode;
  logic        fmt_uint;
  logic [1:0]  fmt_cs;
  logic [7:0]  fmt_b0;
  logic [7:0]  fmt_b1;
  logic [7:0]  fmt_b2;
  logic [7:0]  fmt_b3;
  logic [31:0] fmt_data;

  // Controller side
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_mode, req_uint,
    output req_ready,
    output resp_valid, resp_rdata, resp_err,
    input  resp_ready,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output fmt_mode, fmt_uint, fmt_cs, fmt_b0, fmt_b1, fmt_b2, fmt_b3,
    input  fmt_data
  );

  // Pipeline, memory and formatter side
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_mode, req_uint,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err,
    output resp_ready,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  fmt_mode, fmt_uint, fmt_cs, fmt_b0, fmt_b1, fmt_b2, fmt_b3,
    output fmt_data
  );
endinterface

// File: rtl/lsu_mem_ctrl_store_lane.sv
// Store lane steering: byte enables and lane-replicated write data.
module lsu_store_lane
  import lsu_mem_ctrl_pkg::*;
(
  input  logic [2:0]  mode,
  input  logic [1:0]  cs,
  input  logic [31:0] wdata,
  output logic [3:0]  byte_en,
  output logic [31:0] lane_data
);

  // Replicate the right-aligned data across all lanes.
  // The enables then pick the lanes that memory actually writes.
  always_comb begin
    byte_en   = 4'b0000;
    lane_data = wdata;
    case (mode)
      MODE_B: begin
        byte_en   = 4'b0001 << cs;
        lane_data = {4{wdata[7:0]}};
      end
      MODE_H: begin
        byte_en   = 4'b0011 << cs;
        lane_data = {2{wdata[15:0]}};
      end
      MODE_W: begin
        byte_en   = 4'b1111;
        lane_data = wdata;
      end
      default: begin
        byte_en   = 4'b0000;
        lane_data = wdata;
      end
    endcase
  end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencing controller between the memory pipeline stage and a
// single-port data memory, driving an external load formatter.
module lsu_mem_ctrl
  import lsu_mem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 5
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus,
  output state_t         dbg_state
);

  // Last counter value before the access is abandoned.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  state_t           state;
  state_t           state_nx;

  logic             we_q;
  logic             uint_q;
  logic             err_q;
  logic [31:0]      addr_q;
  logic [31:0]      wdata_q;
  logic [2:0]       mode_q;
  logic [31:0]      rdata_q;
  logic [CNT_W-1:0] cnt;

  logic             accept;
  logic             access_done;
  logic             access_timeout;
  logic             req_err;
  logic [3:0]       lane_we;
  logic [31:0]      lane_wdata;

  lsu_store_lane u_store_lane (
    .mode      (mode_q),
    .cs        (addr_q[1:0]),
    .wdata     (wdata_q),
    .byte_en   (lane_we),
    .lane_data (lane_wdata)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next state and handshake strobes
  always_comb begin
    state_nx       = state;
    accept         = 1'b0;
    access_done    = 1'b0;
    access_timeout = 1'b0;
    bus.req_ready  = 1'b0;
    bus.mem_en     = 1'b0;
    bus.resp_valid = 1'b0;
    req_err        = req_error(bus.req_mode, bus.req_addr[1:0]);
    case (state)
      ST_IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = req_err ? ST_RESP : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        bus.mem_en = 1'b1;
        // A completion on the final cycle still counts as success.
        if (bus.mem_ready) begin
          access_done = 1'b1;
          state_nx    = ST_RESP;
        end else if ((TIMEOUT != 0) && (cnt == TO_LAST)) begin
          access_timeout = 1'b1;
          state_nx       = ST_RESP;
        end
      end
      ST_RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  // Request latch, timeout counter and read-data capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      we_q    <= 1'b0;
      uint_q  <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      mode_q  <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      if (accept) begin
        we_q    <= bus.req_we;
        uint_q  <= bus.req_uint;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        mode_q  <= bus.req_mode;
        err_q   <= req_err;
        cnt     <= '0;
      end
      if ((state == ST_ACCESS) && !bus.mem_ready) cnt <= cnt + 1'b1;
      if (access_done) begin
        err_q <= 1'b0;
        if (!we_q) rdata_q <= bus.mem_rdata;
      end
      if (access_timeout) err_q <= 1'b1;
    end
  end

  assign bus.mem_addr   = {addr_q[31:2], 2'b00};
  assign bus.mem_we     = ((state == ST_ACCESS) && we_q) ? lane_we : 4'b0000;
  assign bus.mem_wdata  = lane_wdata;

  assign bus.resp_err   = (state == ST_RESP) && err_q;
  assign bus.resp_rdata = ((state == ST_RESP) && !err_q && !we_q) ? bus.fmt_data : 32'h0;

  assign bus.fmt_mode   = mode_q;
  assign bus.fmt_uint   = uint_q;
  assign bus.fmt_cs     = addr_q[1:0];
  assign bus.fmt_b0     = rdata_q[7:0];
  assign bus.fmt_b1     = rdata_q[15:8];
  assign bus.fmt_b2     = rdata_q[23:16];
  assign bus.fmt_b3     = rdata_q[31:24];

  assign dbg_state      = state;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural load formatter.
module tb_lsu_mem_ctrl;
  import lsu_mem_ctrl_pkg::*;

  logic   clk;
  logic   rst;
  state_t dbg_state;
  int     errors;
  int     checks;

  lsu_mem_ctrl_if bus ();

  lsu_mem_ctrl #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // External formatter: selects the addressed byte or half and extends it.
  logic [31:0] fmt_word;
  logic [31:0] fmt_shift;
  assign fmt_word  = {bus.fmt_b3, bus.fmt_b2, bus.fmt_b1, bus.fmt_b0};
  assign fmt_shift = fmt_word >> {bus.fmt_cs, 3'b000};
  always_comb begin
    case (bus.fmt_mode)
      3'b001:  bus.fmt_data = {{24{~bus.fmt_uint & fmt_shift[7]}}, fmt_shift[7:0]};
      3'b010:  bus.fmt_data = {{16{~bus.fmt_uint & fmt_shift[15]}}, fmt_shift[15:0]};
      3'b100:  bus.fmt_data = fmt_word;
      default: bus.fmt_data = 32'h0;
    endcase
  end

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  // Presents one request for one cycle (cycle T); returns at the negedge of T+1.
  task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [2:0] mode, input logic uint_ext);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    bus.req_mode  = mode;
    bus.req_uint  = uint_ext;
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  // Called at a negedge while a response is pending; returns one cycle later.
  task automatic finish_resp();
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
  endtask

  // tests
  task automatic test_reset();
    tick();
    #1;
    checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready: got %b want 1", bus.req_ready); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL rst_mem_en: got %b want 0", bus.mem_en); end
    checks++; if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL rst_mem_we: got %b want 0000", bus.mem_we); end
    checks++; if (bus.resp_valid !== 1'b0 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL rst_resp: got valid=%b err=%b want 0 0", bus.resp_valid, bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL rst_resp_rdata: got %h want 0", bus.resp_rdata); end
    checks++; if ({bus.fmt_mode, bus.fmt_uint, bus.fmt_cs} !== 6'b0) begin errors++; $display("FAIL rst_fmt_ctl: got %b want 000000", {bus.fmt_mode, bus.fmt_uint, bus.fmt_cs}); end
    checks++; if (fmt_word !== 32'h0) begin errors++; $display("FAIL rst_fmt_bytes: got %h want 0", fmt_word); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", dbg_state, ST_IDLE); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_word_load();
    issue(1'b0, 32'h104, 32'h0, 3'b100, 1'b0);
    #1;
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL wl_mem_en: got %b want 1", bus.mem_en); end
    checks++; if (bus.mem_addr !== 32'h104) begin errors++; $display("FAIL wl_mem_addr: got %h want 00000104", bus.mem_addr); end
    checks++; if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL wl_mem_we: got %b want 0000", bus.mem_we); end
    checks++; if (bus.fmt_mode !== 3'b100) begin errors++; $display("FAIL wl_fmt_mode: got %b want 100", bus.fmt_mode); end
    checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL wl_req_ready: got %b want 0", bus.req_ready); end
    tick();
    tick();
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'hDEADBEEF;
    #1;
    checks++; if (bus.resp_valid !== 1'b0) begin errors++; $display("FAIL wl_early_resp: got %b want 0 at T+3", bus.resp_valid); end
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL wl_resp_valid: got %b want 1 at T+4", bus.resp_valid); end
    checks++; if (bus.resp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL wl_resp_rdata: got %h want deadbeef", bus.resp_rdata); end
    checks++; if (bus.resp_err !== 1'b0) begin errors++; $display("FAIL wl_resp_err: got %b want 0", bus.resp_err); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL wl_mem_en_drop: got %b want 0", bus.mem_en); end
    finish_resp();
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL wl_after_hs: got valid=%b ready=%b want 0 1", bus.resp_valid, bus.req_ready); end
  endtask

  task automatic test_byte_load();
    logic [31:0] exp_rd [2];
    exp_rd = '{32'hFFFFFF80, 32'h00000080};
    for (int i = 0; i < 2; i++) begin
      issue(1'b0, 32'h203, 32'h0, 3'b001, i[0]);
      #1;
      checks++; if (bus.fmt_cs !== 2'd3) begin errors++; $display("FAIL bl_fmt_cs[%0d]: got %0d want 3", i, bus.fmt_cs); end
      checks++; if (bus.mem_addr !== 32'h200) begin errors++; $display("FAIL bl_mem_addr[%0d]: got %h want 00000200", i, bus.mem_addr); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h80FF0000;
      tick();
      bus.mem_ready = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bl_resp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== exp_rd[i]) begin errors++; $display("FAIL bl_resp_rdata[%0d]: got %h want %h", i, bus.resp_rdata, exp_rd[i]); end
      finish_resp();
    end
  endtask

  task automatic test_store();
    logic [31:0] addr_t [4];
    logic [2:0]  mode_t [4];
    logic [31:0] wd_t   [4];
    logic [31:0] ea_t   [4];
    logic [3:0]  ewe_t  [4];
    logic [31:0] ewd_t  [4];
    addr_t = '{32'h12, 32'h01, 32'h23, 32'h24};
    mode_t = '{3'b010, 3'b001, 3'b001, 3'b100};
    wd_t   = '{32'h0000ABCD, 32'hFFFFFF5A, 32'h00000077, 32'h11223344};
    ea_t   = '{32'h10, 32'h00, 32'h20, 32'h24};
    ewe_t  = '{4'b1100, 4'b0010, 4'b1000, 4'b1111};
    ewd_t  = '{32'hABCDABCD, 32'h5A5A5A5A, 32'h77777777, 32'h11223344};
    for (int i = 0; i < 4; i++) begin
      issue(1'b1, addr_t[i], wd_t[i], mode_t[i], 1'b0);
      #1;
      checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL st_mem_en[%0d]: got %b want 1", i, bus.mem_en); end
      checks++; if (bus.mem_addr !== ea_t[i]) begin errors++; $display("FAIL st_mem_addr[%0d]: got %h want %h", i, bus.mem_addr, ea_t[i]); end
      checks++; if (bus.mem_we !== ewe_t[i]) begin errors++; $display("FAIL st_mem_we[%0d]: got %b want %b", i, bus.mem_we, ewe_t[i]); end
      checks++; if (bus.mem_wdata !== ewd_t[i]) begin errors++; $display("FAIL st_mem_wdata[%0d]: got %h want %h", i, bus.mem_wdata, ewd_t[i]); end
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'h12345678;
      tick();
      bus.mem_ready = 1'b0;
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL st_resp[%0d]: got valid=%b err=%b want 1 0", i, bus.resp_valid, bus.resp_err); end
      checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL st_resp_rdata[%0d]: got %h want 0", i, bus.resp_rdata); end
      checks++; if (bus.mem_we !== 4'b0000) begin errors++; $display("FAIL st_we_drop[%0d]: got %b want 0000", i, bus.mem_we); end
      finish_resp();
    end
  endtask

  task automatic test_errors();
    logic        we_t   [4];
    logic [31:0] addr_t [4];
    logic [2:0]  mode_t [4];
    we_t   = '{1'b0, 1'b0, 1'b0, 1'b1};
    addr_t = '{32'h101, 32'h103, 32'h100, 32'h102};
    mode_t = '{3'b100, 3'b010, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      issue(we_t[i], addr_t[i], 32'hFFFFFFFF, mode_t[i], 1'b0);
      bus.mem_ready = 1'b1;
      bus.mem_rdata = 32'hA5A5A5A5;
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL er_resp[%0d]: got valid=%b err=%b want 1 1 at T+1", i, bus.resp_valid, bus.resp_err); end
      checks++; if (bus.mem_en !== 1'b0 || bus.mem_we !== 4'b0000) begin errors++; $display("FAIL er_mem[%0d]: got en=%b we=%b want 0 0000", i, bus.mem_en, bus.mem_we); end
      checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL er_rdata[%0d]: got %h want 0", i, bus.resp_rdata); end
      tick();
      #1;
      checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL er_hold[%0d]: got valid=%b err=%b en=%b want 1 1 0", i, bus.resp_valid, bus.resp_err, bus.mem_en); end
      bus.mem_ready = 1'b0;
      finish_resp();
      #1;
      checks++; if (bus.req_ready !== 1'b1) begin errors++; $display("FAIL er_idle[%0d]: got %b want 1", i, bus.req_ready); end
    end
  endtask

  task automatic test_timeout();
    int en_cycles;
    // No completion at all: 16 cycles of mem_en, then an error response.
    issue(1'b0, 32'h40, 32'h0, 3'b100, 1'b0);
    en_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      #1;
      if (bus.mem_en === 1'b1) en_cycles++;
      tick();
    end
    #1;
    checks++; if (en_cycles !== 16) begin errors++; $display("FAIL to_en_cycles: got %0d want 16", en_cycles); end
    checks++; if (bus.mem_en !== 1'b0) begin errors++; $display("FAIL to_en_drop: got %b want 0", bus.mem_en); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b1) begin errors++; $display("FAIL to_resp: got valid=%b err=%b want 1 1", bus.resp_valid, bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL to_rdata: got %h want 0", bus.resp_rdata); end
    finish_resp();
    // Completion on the 16th cycle wins over the timeout.
    issue(1'b0, 32'h44, 32'h0, 3'b100, 1'b0);
    en_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) begin
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'hCAFEF00D;
      end
      #1;
      if (bus.mem_en === 1'b1) en_cycles++;
      tick();
    end
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (en_cycles !== 16) begin errors++; $display("FAIL tl_en_cycles: got %0d want 16", en_cycles); end
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0) begin errors++; $display("FAIL tl_resp: got valid=%b err=%b want 1 0", bus.resp_valid, bus.resp_err); end
    checks++; if (bus.resp_rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL tl_rdata: got %h want cafef00d", bus.resp_rdata); end
    finish_resp();
  endtask

  task automatic test_backpressure();
    issue(1'b0, 32'h08, 32'h0, 3'b100, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h0BADF00D;
    tick();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'hFFFFFFFF;
    // A request offered while the response waits must be ignored.
    bus.req_valid = 1'b1;
    bus.req_we    = 1'b1;
    bus.req_addr  = 32'h301;
    bus.req_mode  = 3'b001;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.resp_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d]: got %b want 1", i, bus.resp_valid); end
      checks++; if (bus.resp_rdata !== 32'h0BADF00D) begin errors++; $display("FAIL bp_rdata[%0d]: got %h want 0badf00d", i, bus.resp_rdata); end
      checks++; if (bus.req_ready !== 1'b0) begin errors++; $display("FAIL bp_req_ready[%0d]: got %b want 0", i, bus.req_ready); end
      tick();
    end
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.fmt_mode !== 3'b100 || bus.fmt_cs !== 2'd0) begin errors++; $display("FAIL bp_fmt_held: got mode=%b cs=%0d want 100 0", bus.fmt_mode, bus.fmt_cs); end
    finish_resp();
  endtask

  task automatic test_back_to_back();
    issue(1'b0, 32'h10, 32'h0, 3'b100, 1'b0);
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h600D600D;
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.resp_rdata !== 32'h600D600D) begin errors++; $display("FAIL bb_rdata: got %h want 600d600d", bus.resp_rdata); end
    // Next request offered in the same cycle as the response handshake.
    bus.resp_ready = 1'b1;
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h33;
    bus.req_wdata  = 32'h77;
    bus.req_mode   = 3'b001;
    tick();
    bus.resp_ready = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.mem_en !== 1'b0) begin errors++; $display("FAIL bb_no_bypass: got valid=%b ready=%b en=%b want 0 1 0", bus.resp_valid, bus.req_ready, bus.mem_en); end
    tick();
    bus.req_valid = 1'b0;
    #1;
    checks++; if (bus.mem_en !== 1'b1 || bus.mem_addr !== 32'h30 || bus.mem_we !== 4'b1000) begin errors++; $display("FAIL bb_second: got en=%b addr=%h we=%b want 1 00000030 1000", bus.mem_en, bus.mem_addr, bus.mem_we); end
    bus.mem_ready = 1'b1;
    tick();
    bus.mem_ready = 1'b0;
    #1;
    checks++; if (bus.resp_valid !== 1'b1 || bus.resp_err !== 1'b0 || bus.resp_rdata !== 32'h0) begin errors++; $display("FAIL bb_second_resp: got valid=%b err=%b rdata=%h want 1 0 0", bus.resp_valid, bus.resp_err, bus.resp_rdata); end
    finish_resp();
  endtask

  task automatic test_reset_mid_access();
    issue(1'b0, 32'h50, 32'h0, 3'b100, 1'b0);
    #1;
    checks++; if (bus.mem_en !== 1'b1) begin errors++; $display("FAIL rm_mem_en: got %b want 1", bus.mem_en); end
    tick();
    rst = 1'b1;
    #1;
    checks++; if (bus.mem_en !== 1'b0 || bus.resp_valid !== 1'b0) begin errors++; $display("FAIL rm_drop: got en=%b valid=%b want 0 0", bus.mem_en, bus.resp_valid); end
    tick();
    rst = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = 32'h13579BDF;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (bus.resp_valid !== 1'b0 || bus.mem_en !== 1'b0 || bus.req_ready !== 1'b1) begin errors++; $display("FAIL rm_idle[%0d]: got valid=%b en=%b ready=%b want 0 0 1", i, bus.resp_valid, bus.mem_en, bus.req_ready); end
      tick();
    end
    bus.mem_ready = 1'b0;
  endtask

  // sequence and final report
  initial begin
    errors         = 0;
    checks         = 0;
    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'h0;
    bus.req_mode   = 3'b000;
    bus.req_uint   = 1'b0;
    bus.resp_ready = 1'b0;
    bus.mem_ready  = 1'b0;
    bus.mem_rdata  = 32'h0;

    test_reset();
    test_word_load();
    test_byte_load();
    test_store();
    test_errors();
    test_timeout();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_access();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
